// File: rtl/i2c_arb_pkg.sv
// Shared constants for the i2c request arbiter: FSM state encoding, op codes and
// default timing values.
package i2c_arb_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_GUARD   = 2'd3;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int DEF_TIMEOUT_CYC  = 65535;
    localparam int DEF_WR_GUARD_CYC = 30000;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping
// NREQ-1 -> 0. Returns a one-hot grant and the granted index.
module i2c_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            vld,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!vld && req[(int'(ptr) + k) % NREQ]) begin
                vld = 1'b1;
                idx = PW'((int'(ptr) + k) % NREQ);
            end
        end
        gnt      = '0;
        gnt[idx] = vld;
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin sharing of one byte-level i2c master between NREQ clients, with op timeout.
// Optional post-write tWR blocking state enabled by defining I2C_WR_GUARD_EN.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int WR_GUARD_CYC = DEF_WR_GUARD_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*8-1:0] req_addr,
    input  logic [NREQ*8-1:0] req_wdata,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              m_write_op,
    output logic              m_read_op,
    output logic [7:0]        m_addr,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata,
    input  logic              m_op_done
);

    localparam int          PW      = $clog2(NREQ);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    if (NREQ < 2 || NREQ > 4) begin : g_chk_nreq
        $error("i2c_req_arbiter: NREQ must be 2..4");
    end
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_chk_to
        $error("i2c_req_arbiter: TIMEOUT_CYC must fit the 16-bit timer");
    end
    if (WR_GUARD_CYC < 1) begin : g_chk_guard
        $error("i2c_req_arbiter: WR_GUARD_CYC must be >= 1");
    end

    logic [1:0]      state, state_nx, guard_next;
    logic            guard_done;
    logic [15:0]     tmr;
    logic [PW-1:0]   rr_ptr, gidx;
    logic [NREQ-1:0] gnt_q;
    logic            op_we;
    logic            pick_vld;
    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;

    i2c_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .vld (pick_vld),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

`ifdef I2C_WR_GUARD_EN
    localparam int GW = $clog2(WR_GUARD_CYC + 1);
    logic [GW-1:0] gcnt;

    assign guard_next = (op_we == OP_WR) ? S_GUARD : S_IDLE;
    assign guard_done = (gcnt == GW'(WR_GUARD_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  gcnt <= '0;
        else if (state != S_GUARD) gcnt <= '0;
        else                      gcnt <= gcnt + 1'b1;
    end
`else
    assign guard_next = S_IDLE;
    assign guard_done = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (pick_vld) state_nx = S_ISSUE;
            S_ISSUE:   if (m_op_done || tmr == TO_LAST) state_nx = S_RELEASE;
            // Master must drop op_done before the next grant; a stuck op_done is abandoned.
            S_RELEASE: begin
                if (!m_op_done)          state_nx = guard_next;
                else if (tmr == TO_LAST) state_nx = S_IDLE;
            end
            S_GUARD:   if (guard_done) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        m_write_op = !((state == S_ISSUE) && (op_we == OP_WR));
        m_read_op  = !((state == S_ISSUE) && (op_we == OP_RD));
    end

    // Timer restarts on every state change, so ISSUE and RELEASE each get a full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          tmr <= '0;
        else if (state_nx != state)                       tmr <= '0;
        else if (state == S_ISSUE || state == S_RELEASE)  tmr <= tmr + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr  <= '0;
            m_wdata <= '0;
            op_we   <= OP_RD;
            gidx    <= '0;
            gnt_q   <= '0;
            rr_ptr  <= '0;
            ack     <= '0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            unique case (state)
                S_IDLE: if (pick_vld) begin
                    gidx    <= pick_idx;
                    gnt_q   <= pick_gnt;
                    op_we   <= req_we[pick_idx];
                    m_addr  <= req_addr[8*pick_idx +: 8];
                    m_wdata <= req_wdata[8*pick_idx +: 8];
                end
                S_ISSUE: begin
                    if (m_op_done) begin
                        ack <= gnt_q;
                        if (op_we == OP_RD) rdata <= m_rdata;
                    end else if (tmr == TO_LAST) begin
                        ack <= gnt_q;
                        err <= 1'b1;
                    end
                end
                S_RELEASE: if (!m_op_done || tmr == TO_LAST)
                    rr_ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: behavioural byte-master stub, ack scoreboard,
// timing checks for timeout, reset, back-to-back issue and round-robin fairness.
`timescale 1ns/1ps
module tb_i2c_req_arbiter;

    localparam int NREQ      = 2;
    localparam int TO        = 100;
    localparam int GUARD_CYC = 1000;
`ifdef I2C_WR_GUARD_EN
    localparam int GAP = 3 + GUARD_CYC;
`else
    localparam int GAP = 3;
`endif

    typedef struct {
        int         idx;
        bit         err;
        logic [7:0] rdata;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0, req_we = '0;
    logic [NREQ*8-1:0] req_addr = '0, req_wdata = '0;
    logic [NREQ-1:0]   ack;
    logic              err, busy, m_write_op, m_read_op, m_op_done;
    logic [7:0]        rdata, m_addr, m_wdata, m_rdata;

    i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO), .WR_GUARD_CYC(GUARD_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .err        (err),
        .rdata      (rdata),
        .busy       (busy),
        .m_write_op (m_write_op),
        .m_read_op  (m_read_op),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_op_done  (m_op_done)
    );

    always #83 clk = ~clk;

    // Master stub: mode 0 normal, 1 never completes, 2 completes but never drops op_done.
    int         stub_mode = 0;
    int         stub_lat  = 5;
    int         lat_cnt;
    logic [7:0] mem [256];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_op_done <= 1'b0;
            m_rdata   <= '0;
            lat_cnt   <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
        end else if (!m_op_done) begin
            if ((!m_write_op || !m_read_op) && stub_mode != 1) begin
                if (lat_cnt >= stub_lat) begin
                    m_op_done <= 1'b1;
                    lat_cnt   <= 0;
                    if (!m_write_op) mem[m_addr] <= m_wdata;
                    else             m_rdata     <= mem[m_addr];
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end else if (m_write_op && m_read_op && stub_mode != 2) begin
            m_op_done <= 1'b0;
        end
    end

    exp_t            sb_q[$];
    logic [7:0]      exp_mem [256];
    logic [7:0]      exp_rd;
    int              n_cmp = 0, n_bad = 0;
    int              cyc = 0, n_ack = 0, overlap = 0;
    int              last_issue = 0, last_ack = 0, prev_ack = 0, first_idle = 0;
    bit              op_low_prev = 0, idle_pend = 0, ack_ops_high = 0;
    bit [NREQ-1:0]   auto_drop = '1;

    task automatic preload_model();
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h3C;
        exp_rd = '0;
    endtask

    task automatic push(input int idx, input bit we, input logic [7:0] a,
                        input logic [7:0] d, input bit to);
        exp_t e;
        if (!to) begin
            if (we) exp_mem[a] = d;
            else    exp_rd     = exp_mem[a];
        end
        e.idx   = idx;
        e.err   = to;
        e.rdata = exp_rd;
        sb_q.push_back(e);
    endtask

    task automatic raise(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
        req_we[i]          = we;
        req_addr[8*i +: 8] = a;
        req_wdata[8*i +: 8] = d;
        req[i]             = 1'b1;
    endtask

    // One clock of observation: scoreboard pop on ack, requester drop, timing marks.
    task automatic tick();
        exp_t            e;
        logic [NREQ-1:0] oh;
        @(negedge clk);
        cyc++;
        if (!m_write_op && !m_read_op) overlap++;
        if ((!m_write_op || !m_read_op) && !op_low_prev) last_issue = cyc;
        op_low_prev = !m_write_op || !m_read_op;
        if (idle_pend && !busy) begin
            first_idle = cyc;
            idle_pend  = 0;
        end
        if (ack !== '0) begin
            prev_ack     = last_ack;
            last_ack     = cyc;
            n_ack++;
            idle_pend    = 1;
            ack_ops_high = m_write_op && m_read_op;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL ack_unexpected: ack=%b err=%b at cycle %0d, required no ack", ack, err, cyc);
            end else begin
                e = sb_q.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                if (ack !== oh || err !== e.err || rdata !== e.rdata) begin
                    n_bad++;
                    $display("FAIL ack_check: got ack=%b err=%b rdata=%h, required ack=%b err=%b rdata=%h",
                             ack, err, rdata, oh, e.err, e.rdata);
                end
            end
            for (int i = 0; i < NREQ; i++)
                if (ack[i] && (auto_drop[i] || sb_q.size() == 0)) req[i] = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sb_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        preload_model();
        sb_q.delete();
        tick();
    endtask

    task automatic test_reset();
        logic [21:0] got;
        tick();
        tick();
        got = {ack, err, rdata, busy, m_write_op, m_read_op, m_addr[0], m_wdata[0], m_addr[7:1] | m_wdata[7:1]};
        n_cmp++;
        if (got !== {2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'h00}) begin
            n_bad++;
            $display("FAIL reset_state: got %h, required %h", got,
                     {2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'h00});
        end
        rst = 1'b0;
        preload_model();
        tick();
    endtask

    task automatic test_write_read();
        bit ok;
        raise(0, 1'b1, 8'h55, 8'hAA);
        push(0, 1'b1, 8'h55, 8'hAA, 1'b0);
        wait_drain(300, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL wr_drain: timed out, %0d outstanding, required 0", sb_q.size()); sb_q.delete(); end
        raise(0, 1'b0, 8'h55, 8'h00);
        push(0, 1'b0, 8'h55, 8'h00, 1'b0);
        wait_drain(300, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rd_drain: timed out, %0d outstanding, required 0", sb_q.size()); sb_q.delete(); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            // Second pass only orders 0 before 1 if the pointer wrapped back to 0.
            raise(0, 1'b0, 8'h55, 8'h00);
            raise(1, 1'b0, 8'h12, 8'h00);
            push(0, 1'b0, 8'h55, 8'h00, 1'b0);
            push(1, 1'b0, 8'h12, 8'h00, 1'b0);
            wait_drain(400, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL simul_drain: pass %0d timed out, %0d outstanding", pass, sb_q.size()); sb_q.delete(); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        stub_mode = 1;
        raise(0, 1'b1, 8'h20, 8'h77);
        push(0, 1'b1, 8'h20, 8'h77, 1'b1);
        wait_drain(400, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL to_drain: timed out, %0d outstanding", sb_q.size()); sb_q.delete(); end
        n_cmp++;
        if (last_ack - last_issue !== TO) begin
            n_bad++;
            $display("FAIL to_latency: ack %0d clk after issue, required %0d", last_ack - last_issue, TO);
        end
        n_cmp++;
        if (ack_ops_high !== 1'b1) begin n_bad++; $display("FAIL to_op_release: ops high at ack=%b, required 1", ack_ops_high); end
        n_cmp++;
        if (first_idle - last_ack !== 1) begin
            n_bad++;
            $display("FAIL to_idle: idle %0d clk after ack, required 1", first_idle - last_ack);
        end
        stub_mode = 0;
    endtask

    task automatic test_stuck_done();
        bit ok;
        stub_mode = 2;
        raise(1, 1'b0, 8'h30, 8'h00);
        push(1, 1'b0, 8'h30, 8'h00, 1'b0);
        wait_drain(400, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL stuck_drain: timed out, %0d outstanding", sb_q.size()); sb_q.delete(); end
        n_cmp++;
        if (first_idle - last_ack !== TO) begin
            n_bad++;
            $display("FAIL stuck_release: idle %0d clk after ack, required %0d", first_idle - last_ack, TO);
        end
        stub_mode = 0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset_in_issue();
        bit          ok;
        int          n0;
        logic [11:0] got;
        stub_mode = 1;
        raise(0, 1'b1, 8'h40, 8'h11);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (m_write_op === 1'b0) ok = 1;
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rst_issue_wait: write op not asserted within 10 clk"); end
        tick();
        tick();
        rst = 1'b1;
        #1;
        got = {m_write_op, m_read_op, busy, ack, rdata[6:0]};
        n_cmp++;
        if (got !== {1'b1, 1'b1, 1'b0, 2'b00, 7'h00} || rdata[7] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_issue_outputs: wr=%b rd=%b busy=%b ack=%b rdata=%h, required 1 1 0 00 00",
                     m_write_op, m_read_op, busy, ack, rdata);
        end
        req = '0;
        n0  = n_ack;
        tick();
        tick();
        rst = 1'b0;
        preload_model();
        stub_mode = 0;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (n_ack !== n0) begin n_bad++; $display("FAIL rst_issue_no_ack: %0d acks after reset, required 0", n_ack - n0); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        raise(0, 1'b1, 8'h60, 8'h5A);
        raise(1, 1'b0, 8'h60, 8'h00);
        push(0, 1'b1, 8'h60, 8'h5A, 1'b0);
        push(1, 1'b0, 8'h60, 8'h00, 1'b0);
        wait_drain(3000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL b2b_drain: timed out, %0d outstanding", sb_q.size()); sb_q.delete(); end
        n_cmp++;
        if (last_issue - prev_ack !== GAP) begin
            n_bad++;
            $display("FAIL b2b_gap: read issued %0d clk after write ack, required %0d", last_issue - prev_ack, GAP);
        end
    endtask

    task automatic test_no_starve();
        bit ok;
        auto_drop[1] = 1'b0;
        raise(1, 1'b0, 8'h12, 8'h00);
        push(1, 1'b0, 8'h12, 8'h00, 1'b0);
        push(0, 1'b0, 8'h13, 8'h00, 1'b0);
        push(1, 1'b0, 8'h12, 8'h00, 1'b0);
        ok = 0;
        for (int i = 0; i < 5 && !ok; i++) begin
            tick();
            if (busy === 1'b1) ok = 1;
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL starve_grant: req1 not granted within 5 clk"); end
        raise(0, 1'b0, 8'h13, 8'h00);
        wait_drain(600, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL starve_drain: timed out, %0d outstanding", sb_q.size()); sb_q.delete(); end
        auto_drop[1] = 1'b1;
        req = '0;
    endtask

    task automatic test_no_overlap();
        n_cmp++;
        if (overlap !== 0) begin n_bad++; $display("FAIL op_overlap: both ops low in %0d cycles, required 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_timeout();
        test_stuck_done();
        test_reset_in_issue();
        test_back_to_back();
        test_no_starve();
        test_no_overlap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
